// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction register / control FSM.
// Opcode, op, write-back select and ALU operation constants live here.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    typedef enum logic [2:0] {
        C_MOV_IMM,
        C_MOV_REG,
        C_ADD,
        C_CMP,
        C_AND,
        C_MVN,
        C_BAD
    } iclass_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [3:0] VSEL_NONE  = 4'b0000;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_C     = 4'b0001;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_NOTB   = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decode: register fields, shift field,
// sign-extended immediates and the instruction class.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [2:0]  rn_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rm_o,
    output logic [1:0]  sh_o,
    output iclass_t     iclass_o,
    output logic [15:0] sximm8_o,
    output logic [15:0] sximm5_o
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode   = ir_i[15:13];
    assign op       = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
    assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

    always_comb begin
        iclass_o = C_BAD;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)
                iclass_o = C_MOV_IMM;
            else if (op == OP_MOV_REG)
                iclass_o = C_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  iclass_o = C_ADD;
                OP_CMP:  iclass_o = C_CMP;
                OP_AND:  iclass_o = C_AND;
                default: iclass_o = C_MVN;
            endcase
        end
    end

endmodule

// File: rtl/instr_fsm.sv
// Instruction register plus the control FSM that sequences the datapath
// through read, ALU and write-back for one instruction per start request.
module instr_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    state_t      state_q, state_d;
    logic [15:0] ir_q;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    iclass_t     iclass;

    instr_dec u_dec (
        .ir_i     (ir_q),
        .rn_o     (rn),
        .rd_o     (rd),
        .rm_o     (rm),
        .sh_o     (sh),
        .iclass_o (iclass),
        .sximm8_o (sximm8),
        .sximm5_o (sximm5)
    );

    // IR only loads while idle so it stays stable for the whole instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir_q <= 16'h0000;
        else if (state_q == S_WAIT && load)
            ir_q <= in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_WAIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        w        = 1'b0;
        err      = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        vsel     = VSEL_NONE;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = ALU_ADD;

        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                case (iclass)
                    C_MOV_IMM:               state_d = S_WRITE_IMM;
                    C_MOV_REG, C_MVN:        state_d = S_GET_B;
                    C_ADD, C_CMP, C_AND:     state_d = S_GET_A;
                    default: begin
                        err     = 1'b1;
                        state_d = S_WAIT;
                    end
                endcase
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_ALU;
            end
            S_ALU: begin
                shift = sh;
                loadc = (iclass != C_CMP);
                loads = (iclass == C_CMP);
                case (iclass)
                    C_MOV_REG: begin
                        ALUop = ALU_ADD;
                        asel  = 1'b1;   // A forced to 0 so the ALU passes shifted Rm
                    end
                    C_CMP:   ALUop = ALU_SUB;
                    C_AND:   ALUop = ALU_AND;
                    C_MVN:   ALUop = ALU_NOTB;
                    default: ALUop = ALU_ADD;
                endcase
                state_d = (iclass == C_CMP) ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                vsel     = VSEL_C;
                writenum = rd;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            S_WRITE_IMM: begin
                vsel     = VSEL_IMM8;
                writenum = rn;
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_instr_fsm.sv
// Bench for instr_fsm: a behavioural datapath is driven by the DUT controls,
// and an instruction-level reference model predicts registers, flags and timing.
module tb_instr_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s = 1'b0;
    logic        load = 1'b0;
    logic [15:0] in_r = 16'h0000;
    logic        w, err;
    logic [2:0]  readnum, writenum;
    logic [3:0]  vsel;
    logic        loada, loadb, loadc, loads, write, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8, sximm5;

    instr_fsm dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load     (load),
        .in       (in_r),
        .w        (w),
        .err      (err),
        .readnum  (readnum),
        .writenum (writenum),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    always #5 clk = ~clk;

    logic [20:0] ctrl_v;
    assign ctrl_v = {readnum, writenum, vsel, loada, loadb, loadc, loads,
                     write, asel, bsel, shift, ALUop};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] shf(input logic [15:0] b, input logic [1:0] sh);
        if (sh == 2'b01)      return b << 1;
        else if (sh == 2'b10) return b >> 1;
        else if (sh == 2'b11) return {b[15], b[15:1]};
        else                  return b;
    endfunction

    function automatic logic [15:0] sx8(input logic [15:0] x);
        return {{8{x[7]}}, x[7:0]};
    endfunction

    function automatic logic [15:0] sx5(input logic [15:0] x);
        return {{11{x[4]}}, x[4:0]};
    endfunction

    // Behavioural datapath: controls sampled mid-cycle, applied at the next edge.
    logic [15:0] dp_r [8] = '{default: 16'h0000};
    logic [15:0] dp_a = 16'h0, dp_b = 16'h0, dp_c = 16'h0;
    logic        dp_z = 1'b0, dp_n = 1'b0, dp_v = 1'b0;
    logic [2:0]  sn_readnum = 3'd0, sn_writenum = 3'd0;
    logic [3:0]  sn_vsel = 4'd0;
    logic        sn_loada = 1'b0, sn_loadb = 1'b0, sn_loadc = 1'b0;
    logic        sn_loads = 1'b0, sn_write = 1'b0, sn_asel = 1'b0;
    logic [1:0]  sn_shift = 2'd0, sn_aluop = 2'd0;
    logic [15:0] sn_imm8 = 16'h0;
    logic [15:0] ain, bin, alu, wdata;

    always @(negedge clk) begin
        sn_readnum  <= readnum;
        sn_writenum <= writenum;
        sn_vsel     <= vsel;
        sn_loada    <= loada;
        sn_loadb    <= loadb;
        sn_loadc    <= loadc;
        sn_loads    <= loads;
        sn_write    <= write;
        sn_asel     <= asel;
        sn_shift    <= shift;
        sn_aluop    <= ALUop;
        sn_imm8     <= sximm8;
    end

    always_comb begin
        ain = sn_asel ? 16'h0000 : dp_a;
        bin = shf(dp_b, sn_shift);
        case (sn_aluop)
            2'b00:   alu = ain + bin;
            2'b01:   alu = ain - bin;
            2'b10:   alu = ain & bin;
            default: alu = ~bin;
        endcase
        case (sn_vsel)
            4'b0100: wdata = sn_imm8;
            4'b0001: wdata = dp_c;
            default: wdata = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (sn_loada) dp_a <= dp_r[sn_readnum];
            if (sn_loadb) dp_b <= dp_r[sn_readnum];
            if (sn_loadc) dp_c <= alu;
            if (sn_loads) begin
                dp_z <= (alu == 16'h0000);
                dp_n <= alu[15];
                dp_v <= (ain[15] != bin[15]) && (alu[15] != ain[15]);
            end
            if (sn_write) dp_r[sn_writenum] <= wdata;
        end
    end

    // Instruction-level reference model.
    typedef struct packed {
        int               busy;
        int               err_cyc;
        int               idle;
        logic [15:0]      instr;
        logic [7:0][15:0] regs;
        logic             z;
        logic             n;
        logic             v;
    } exp_t;

    exp_t             exp_q[$];
    logic [7:0][15:0] ref_regs = '0;
    logic             ref_z = 1'b0, ref_n = 1'b0, ref_v = 1'b0;
    logic [15:0]      ir_tb = 16'h0000;
    bit               mon_en = 1'b0;

    task automatic ref_exec(input logic [15:0] ins, output int busy, output int errc);
        logic [2:0]  opc, rn, rd, rm;
        logic [1:0]  op, sh;
        logic [15:0] bs, diff;
        opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
        rd  = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
        bs   = shf(ref_regs[rm], sh);
        busy = 1;
        errc = 0;
        if (opc == 3'b110 && op == 2'b10) begin
            ref_regs[rn] = sx8(ins);
            busy = 2;
        end else if (opc == 3'b110 && op == 2'b00) begin
            ref_regs[rd] = bs;
            busy = 4;
        end else if (opc == 3'b101) begin
            case (op)
                2'b00: begin ref_regs[rd] = ref_regs[rn] + bs; busy = 5; end
                2'b01: begin
                    diff  = ref_regs[rn] - bs;
                    ref_z = (diff == 16'h0000);
                    ref_n = diff[15];
                    ref_v = (ref_regs[rn][15] != bs[15]) && (diff[15] != ref_regs[rn][15]);
                    busy  = 4;
                end
                2'b10: begin ref_regs[rd] = ref_regs[rn] & bs; busy = 5; end
                default: begin ref_regs[rd] = ~bs; busy = 4; end
            endcase
        end else begin
            errc = 1;
        end
    endtask

    // Monitor: counts busy/idle cycles and checks each completed instruction.
    initial begin
        int   busy, errc, idle, idle_before;
        bit   active;
        exp_t e;
        busy = 0; errc = 0; idle = 0; idle_before = 0; active = 0;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                busy = 0; errc = 0; idle = 0; active = 0;
            end else if (!w) begin
                if (!active) begin
                    active = 1; idle_before = idle; busy = 0; errc = 0;
                end
                busy++;
                if (err) errc++;
                if (exp_q.size() > 0) begin
                    chk("sximm8", sximm8, sx8(exp_q[0].instr));
                    chk("sximm5", sximm5, sx5(exp_q[0].instr));
                end
            end else begin
                if (active) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL completion: got an instruction, expected none pending");
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_cycles", busy, e.busy);
                        chk("err_cycles", errc, e.err_cyc);
                        if (e.idle >= 0) chk("wait_cycles", idle_before, e.idle);
                        for (int i = 0; i < 8; i++)
                            chk($sformatf("R%0d", i), dp_r[i], e.regs[i]);
                        chk("flags_ZNV", {dp_z, dp_n, dp_v}, {e.z, e.n, e.v});
                    end
                    idle = 1;
                end else begin
                    idle++;
                end
                active = 0;
                chk("err_in_wait", err, 1'b0);
            end
        end
    end

    // Must be called at a falling edge inside a WAIT cycle.
    task automatic issue(input logic [15:0] ins, input bit do_load, input bit keep_s,
                         input bit noise, input int exp_idle);
        exp_t        e;
        int          b, ec, k;
        logic [15:0] eff;
        eff = do_load ? ins : ir_tb;
        if (do_load) ir_tb = ins;
        ref_exec(eff, b, ec);
        e.busy = b; e.err_cyc = ec; e.idle = exp_idle; e.instr = eff;
        e.regs = ref_regs; e.z = ref_z; e.n = ref_n; e.v = ref_v;
        exp_q.push_back(e);
        $display("[TB] issue ir=%04h load=%0d keep_s=%0d noise=%0d busy_exp=%0d err_exp=%0d",
                 eff, do_load, keep_s, noise, b, ec);
        in_r = ins; load = do_load; s = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (!keep_s) s = 1'b0;
        k = 0;
        while (!w && k < 16) begin
            if (noise) begin
                in_r = 16'($urandom);
                load = 1'($urandom_range(0, 1));
                if (!keep_s) s = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            k++;
        end
        if (!w) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: w still 0 after %0d cycles, expected 1", k);
        end
        load = 1'b0;
        if (!keep_s) s = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        int          k, x;
        r = 16'($urandom);
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 9: r[15:11] = 5'b11010;
            2:       r[15:11] = 5'b11000;
            3:       r[15:11] = 5'b10100;
            4:       r[15:11] = 5'b10101;
            5:       r[15:11] = 5'b10110;
            6:       r[15:11] = 5'b10111;
            7: begin
                x = $urandom_range(0, 4);
                r[15:13] = (x == 4) ? 3'b111 : 3'(x);
            end
            default: r[15:11] = $urandom_range(0, 1) ? 5'b11001 : 5'b11011;
        endcase
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_w", w, 1'b1);
        chk("rst_err", err, 1'b0);
        chk("rst_ctrl", ctrl_v, 21'd0);
        chk("rst_sximm8", sximm8, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ctrl", ctrl_v, 21'd0);
        mon_en = 1'b1;

        issue(16'hD007, 1, 0, 0, -1);
        issue(16'hD0F6, 1, 0, 0, 1);
        chk("sximm8_D0F6", sximm8, 16'hFFF6);
        issue(16'hD007, 1, 0, 0, 1);
        issue(16'hD102, 1, 0, 0, 1);
        issue(16'hA140, 1, 0, 1, 1);
        issue(16'hA900, 1, 0, 0, 1);
        issue(16'hD506, 1, 0, 0, 1);
        issue(16'hB8ED, 1, 0, 0, 1);
        issue(16'hD40A, 1, 0, 0, 1);
        issue(16'hC074, 1, 0, 0, 1);
        issue(16'hE000, 1, 0, 0, 1);
        issue(16'hD20A, 1, 1, 0, 1);
        issue(16'hD30B, 1, 1, 0, 1);
        issue(16'hD41C, 1, 0, 0, 1);

        // Reset in the middle of an ADD: nothing may be written.
        mon_en = 1'b0;
        in_r = 16'hA140; load = 1'b1; s = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("getb_loadb", loadb, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ctrl", ctrl_v, 21'd0);
        chk("midrst_w", w, 1'b1);
        chk("midrst_err", err, 1'b0);
        chk("midrst_sximm8", sximm8, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        ir_tb = 16'h0000;
        mon_en = 1'b1;
        @(negedge clk);
        issue(16'hD0FF, 0, 0, 0, -1);

        for (int i = 0; i < 200; i++) begin
            int gap;
            bit ks, nz, ld;
            gap = $urandom_range(0, 2);
            ks  = 1'($urandom_range(0, 1));
            nz  = 1'($urandom_range(0, 1));
            ld  = ($urandom_range(0, 4) != 0);
            if (gap > 0) begin
                s = 1'b0;
                repeat (gap) @(negedge clk);
            end
            issue(rand_instr(), ld, ks, nz, gap + 1);
        end
        s = 1'b0;
        load = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
